// File: rtl/rf_pkg.sv
// Shared types for the superscalar register file / ROB-tag scoreboard.
package rf_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] value;
        rob_tag_t        rob;
    } commit_slot_t;

    typedef struct packed {
        logic       valid;
        logic       writes_rd;
        logic [4:0] rd;
        rob_tag_t   rob;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } issue_slot_t;

    typedef struct packed {
        logic [XLEN-1:0] value;
        rob_tag_t        rob;
        logic            ready;
    } operand_t;

endpackage

// File: rtl/rf_read_port.sv
// Combinational operand resolution for one source register of issue slot SLOT.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned ISSUE_WIDTH  = 2,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned SLOT         = 0
) (
    input  logic [4:0]                              src_i,
    input  logic [ISSUE_WIDTH-1:0]                  issue_valid_i,
    input  logic [ISSUE_WIDTH-1:0]                  issue_writes_rd_i,
    input  logic [ISSUE_WIDTH-1:0][4:0]             issue_rd_i,
    input  logic [ISSUE_WIDTH-1:0][TAG_W-1:0]       issue_rob_i,
    input  logic [COMMIT_WIDTH-1:0]                 commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]       commit_v_i,
    input  logic [COMMIT_WIDTH-1:0][TAG_W-1:0]      commit_rob_i,
    input  logic [XLEN-1:0]                         rf_v_i,
    input  logic [TAG_W-1:0]                        tag_i,
    input  logic                                    tag_valid_i,
    output logic [XLEN-1:0]                         value_o,
    output logic [TAG_W-1:0]                        rob_o,
    output logic                                    ready_o
);

    logic             older_hit;
    logic [TAG_W-1:0] older_rob;
    logic             byp_hit;
    logic [XLEN-1:0]  byp_v;

    always_comb begin
        older_hit = 1'b0;
        older_rob = '0;
        // Ascending scan so the youngest older writer wins.
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            if (i < int'(SLOT) && issue_valid_i[i] && issue_writes_rd_i[i] &&
                issue_rd_i[i] == src_i) begin
                older_hit = 1'b1;
                older_rob = issue_rob_i[i];
            end
        end

        byp_hit = 1'b0;
        byp_v   = '0;
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            if (commit_valid_i[k] && commit_rob_i[k] == tag_i) begin
                byp_hit = 1'b1;
                byp_v   = commit_v_i[k];
            end
        end

        value_o = '0;
        rob_o   = '0;
        ready_o = 1'b1;
        if (src_i == 5'd0) begin
            ready_o = 1'b1;
        end else if (older_hit) begin
            ready_o = 1'b0;
            rob_o   = older_rob;
        end else if (tag_valid_i && byp_hit) begin
            value_o = byp_v;
        end else if (tag_valid_i) begin
            ready_o = 1'b0;
            rob_o   = tag_i;
        end else begin
            value_o = rf_v_i;
        end
    end

endmodule

// File: rtl/regfile_scoreboard_ss.sv
// Superscalar architectural register file with per-register ROB-tag scoreboard.
module regfile_scoreboard_ss
    import rf_pkg::*;
#(
    parameter int unsigned XLEN         = rf_pkg::XLEN,
    parameter int unsigned ROB_DEPTH    = rf_pkg::ROB_DEPTH,
    parameter int unsigned ISSUE_WIDTH  = 2,
    parameter int unsigned COMMIT_WIDTH = 2,
    localparam int unsigned TAG_W       = $clog2(ROB_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid,
    input  logic [COMMIT_WIDTH-1:0][4:0]        commit_rd_s,
    input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]   commit_rd_v,
    input  logic [COMMIT_WIDTH-1:0][TAG_W-1:0]  commit_rob,
    input  logic [ISSUE_WIDTH-1:0]              issue_valid,
    input  logic [ISSUE_WIDTH-1:0]              issue_writes_rd,
    input  logic [ISSUE_WIDTH-1:0][4:0]         issue_rd_s,
    input  logic [ISSUE_WIDTH-1:0][TAG_W-1:0]   issue_rob,
    input  logic [ISSUE_WIDTH-1:0][4:0]         issue_rs1_s,
    input  logic [ISSUE_WIDTH-1:0][4:0]         issue_rs2_s,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]    rs1_v,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]    rs2_v,
    output logic [ISSUE_WIDTH-1:0][TAG_W-1:0]   rs1_rob,
    output logic [ISSUE_WIDTH-1:0][TAG_W-1:0]   rs2_rob,
    output logic [ISSUE_WIDTH-1:0]              rs1_ready,
    output logic [ISSUE_WIDTH-1:0]              rs2_ready
);

    logic [XLEN-1:0]  rf_q  [32];
    logic [XLEN-1:0]  rf_d  [32];
    logic [TAG_W-1:0] tag_q [32];
    logic [TAG_W-1:0] tag_d [32];
    logic [31:0]      tag_valid_q;
    logic [31:0]      tag_valid_d;

    logic [ISSUE_WIDTH-1:0][XLEN-1:0]  op1_v, op2_v;
    logic [ISSUE_WIDTH-1:0][TAG_W-1:0] op1_rob, op2_rob;
    logic [ISSUE_WIDTH-1:0]            op1_ready, op2_ready;

    always_comb begin
        rf_d        = rf_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;

        // Commit clears a tag only on exact match, so a reused ROB index can't free a newer producer.
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            if (commit_valid[k] && commit_rd_s[k] != 5'd0) begin
                rf_d[commit_rd_s[k]] = commit_rd_v[k];
                if (tag_valid_q[commit_rd_s[k]] && tag_q[commit_rd_s[k]] == commit_rob[k]) begin
                    tag_valid_d[commit_rd_s[k]] = 1'b0;
                end
            end
        end

        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            if (issue_valid[i] && issue_writes_rd[i] && issue_rd_s[i] != 5'd0) begin
                tag_d[issue_rd_s[i]]       = issue_rob[i];
                tag_valid_d[issue_rd_s[i]] = 1'b1;
            end
        end

        if (flush) begin
            tag_valid_d = '0;
            for (int r = 0; r < 32; r++) begin
                tag_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                rf_q[r]  <= '0;
                tag_q[r] <= '0;
            end
            tag_valid_q <= '0;
        end else begin
            rf_q        <= rf_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_slot
        rf_read_port #(
            .XLEN         (XLEN),
            .TAG_W        (TAG_W),
            .ISSUE_WIDTH  (ISSUE_WIDTH),
            .COMMIT_WIDTH (COMMIT_WIDTH),
            .SLOT         (j)
        ) u_rs1 (
            .src_i             (issue_rs1_s[j]),
            .issue_valid_i     (issue_valid),
            .issue_writes_rd_i (issue_writes_rd),
            .issue_rd_i        (issue_rd_s),
            .issue_rob_i       (issue_rob),
            .commit_valid_i    (commit_valid),
            .commit_v_i        (commit_rd_v),
            .commit_rob_i      (commit_rob),
            .rf_v_i            (rf_q[issue_rs1_s[j]]),
            .tag_i             (tag_q[issue_rs1_s[j]]),
            .tag_valid_i       (tag_valid_q[issue_rs1_s[j]]),
            .value_o           (op1_v[j]),
            .rob_o             (op1_rob[j]),
            .ready_o           (op1_ready[j])
        );

        rf_read_port #(
            .XLEN         (XLEN),
            .TAG_W        (TAG_W),
            .ISSUE_WIDTH  (ISSUE_WIDTH),
            .COMMIT_WIDTH (COMMIT_WIDTH),
            .SLOT         (j)
        ) u_rs2 (
            .src_i             (issue_rs2_s[j]),
            .issue_valid_i     (issue_valid),
            .issue_writes_rd_i (issue_writes_rd),
            .issue_rd_i        (issue_rd_s),
            .issue_rob_i       (issue_rob),
            .commit_valid_i    (commit_valid),
            .commit_v_i        (commit_rd_v),
            .commit_rob_i      (commit_rob),
            .rf_v_i            (rf_q[issue_rs2_s[j]]),
            .tag_i             (tag_q[issue_rs2_s[j]]),
            .tag_valid_i       (tag_valid_q[issue_rs2_s[j]]),
            .value_o           (op2_v[j]),
            .rob_o             (op2_rob[j]),
            .ready_o           (op2_ready[j])
        );
    end

    // While reset is held, same-cycle bypass/intra-bundle paths must not leak through.
    always_comb begin
        for (int j = 0; j < int'(ISSUE_WIDTH); j++) begin
            rs1_v[j]     = rst ? '0   : op1_v[j];
            rs2_v[j]     = rst ? '0   : op2_v[j];
            rs1_rob[j]   = rst ? '0   : op1_rob[j];
            rs2_rob[j]   = rst ? '0   : op2_rob[j];
            rs1_ready[j] = rst ? 1'b1 : op1_ready[j];
            rs2_ready[j] = rst ? 1'b1 : op2_ready[j];
        end
    end

endmodule
